// File: rtl/svfifo_mc.sv
// Multi-channel runtime-depth delay line: NCH lanes share one circular write pointer.
// Latency: a sample accepted on dv cycle n appears on fifo_out on dv cycle n+depth_q; svcoeff is zero-latency.
// Backpressure: none; dv is a shift enable, and idle cycles (dv=0) freeze the line and zero the outputs.
module svfifo_mc #(
    parameter int CWIDTH   = 9,
    parameter int NCH      = 4,
    parameter int MAXDEPTH = 32,
    parameter int AW       = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  dv,
    input  logic                  flush,
    input  logic [AW:0]           depth,
    input  logic [NCH*CWIDTH-1:0] fifo_in,
    output logic [NCH*CWIDTH-1:0] fifo_out,
    output logic [NCH*CWIDTH-1:0] svcoeff,
    output logic                  out_valid,
    output logic                  primed,
    output logic [AW:0]           fill
);

    localparam logic [AW:0] DMAX = (AW+1)'(MAXDEPTH);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]       fill_q, fill_d;
    logic [AW:0]       depth_q, depth_d;
    logic [AW-1:0]     rd_ptr;
    logic              wr_en;
    logic              depth_chg;
    logic [CWIDTH-1:0] mem_q [NCH][MAXDEPTH];

    // Clamp the requested depth into 1..MAXDEPTH; this is the value depth_q tracks.
    always_comb begin
        depth_d = depth;
        if (depth == '0) begin
            depth_d = (AW+1)'(1);
        end else if (depth > DMAX) begin
            depth_d = DMAX;
        end
    end

    // Pointer and fill next-state: flush or a depth change empties the line logically.
    always_comb begin
        wr_en     = dv & ~flush;
        depth_chg = (depth_d != depth_q);
        wr_ptr_d  = wr_ptr_q;
        fill_d    = fill_q;
        if (flush) begin
            wr_ptr_d = '0;
        end else if (dv) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (flush || depth_chg) begin
            fill_d = '0;
        end else if (dv && (fill_q != DMAX)) begin
            fill_d = fill_q + (AW+1)'(1);
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            fill_q   <= '0;
            depth_q  <= (AW+1)'(1);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            depth_q  <= depth_d;
        end
    end

    // Sample storage, not reset; stale content is hidden by the priming gate.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int ch = 0; ch < NCH; ch++) begin
                mem_q[ch][wr_ptr_q] <= fifo_in[ch*CWIDTH +: CWIDTH];
            end
        end
    end

    // Combinational read; at full depth rd_ptr==wr_ptr and the old entry is read before overwrite.
    always_comb begin
        rd_ptr    = wr_ptr_q - depth_q[AW-1:0];
        primed    = (fill_q >= depth_q);
        out_valid = dv & primed;
        fill      = fill_q;
        svcoeff   = dv ? fifo_in : '0;
        fifo_out  = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            if (out_valid) begin
                fifo_out[ch*CWIDTH +: CWIDTH] = mem_q[ch][rd_ptr];
            end
        end
    end

endmodule
